// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: single-precision word, sign position and
// the add/sub opcode encoding used by the issue wrappers.
package fpu_pkg;

  typedef logic [31:0] float_t;

  localparam int   SIGN_BIT = 31;
  localparam logic OP_SUB   = 1'b0;
  localparam logic OP_ADD   = 1'b1;

  // a + b is issued to the subtractor as a - (-b)
  function automatic float_t negate(input float_t x);
    float_t r;
    r           = x;
    r[SIGN_BIT] = ~x[SIGN_BIT];
    return r;
  endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Circular result FIFO with a combinational head and an occupancy count.
// The head reads as zero while the FIFO is empty.
module fpu_result_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 36
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [W-1:0]  mem [DEPTH];
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wrap_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= wrap_inc(rd_ptr_reg);
      count_reg <= count_next;
    end
  end

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr_reg];
  assign count     = count_reg;

  // The issuer's credit check guarantees a free slot for every write.
  assert property (@(posedge clk) disable iff (!rstn) push |-> !full)
    else $error("fpu_result_fifo: write into a full FIFO");

endmodule

// File: rtl/fsub_issue.sv
// Issue/writeback wrapper for a fixed-latency, non-stallable fsub pipeline:
// operand registers, valid/tag shadow pipe, credit check and result FIFO.
module fsub_issue
  import fpu_pkg::*;
#(
  parameter int LAT   = 3,
  parameter int DEPTH = 8,
  parameter int TAGW  = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_op,
  input  logic [31:0]     in_x1,
  input  logic [31:0]     in_x2,
  input  logic [TAGW-1:0] in_tag,
  output logic [31:0]     fs_x1,
  output logic [31:0]     fs_x2,
  input  logic [31:0]     fs_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_y,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);

  localparam int IW = $clog2(LAT+1);
  localparam int CW = $clog2(DEPTH+1);
  localparam int FW = 32 + TAGW;

  float_t          fs_x1_reg, fs_x2_reg;
  logic [LAT:1]    v_reg;
  logic [TAGW-1:0] tag_reg [1:LAT];
  logic [IW-1:0]   inflight;
  logic [CW-1:0]   fifo_count;
  logic [FW-1:0]   fifo_head;
  logic            fifo_empty, fifo_full;
  logic            accept;

  always_comb begin
    inflight = '0;
    for (int k = 1; k <= LAT; k++) inflight = inflight + IW'(v_reg[k]);
  end

  // Credit counts everything already committed to the FIFO; a pop in this
  // same cycle is deliberately not credited, keeping in_ready off the
  // out_ready path.
  assign in_ready = rstn && ((int'(fifo_count) + int'(inflight)) < DEPTH);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fs_x1_reg <= '0;
      fs_x2_reg <= '0;
      v_reg     <= '0;
      for (int k = 1; k <= LAT; k++) tag_reg[k] <= '0;
    end else begin
      if (accept) begin
        fs_x1_reg  <= in_x1;
        fs_x2_reg  <= (in_op == OP_ADD) ? negate(in_x2) : in_x2;
        v_reg[1]   <= 1'b1;
        tag_reg[1] <= in_tag;
      end else begin
        fs_x1_reg <= '0;
        fs_x2_reg <= '0;
        v_reg[1]  <= 1'b0;
      end
      for (int k = LAT; k >= 2; k--) begin
        v_reg[k]   <= v_reg[k-1];
        tag_reg[k] <= tag_reg[k-1];
      end
    end
  end

  fpu_result_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (v_reg[LAT]),
    .push_data ({fs_y, tag_reg[LAT]}),
    .pop       (out_ready),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign fs_x1     = fs_x1_reg;
  assign fs_x2     = fs_x2_reg;
  assign out_valid = !fifo_empty;
  assign out_y     = fifo_head[FW-1:TAGW];
  assign out_tag   = fifo_head[TAGW-1:0];
  assign busy      = (|v_reg) || (fifo_count != '0);

endmodule

// File: tb/tb_fsub_issue.sv
// Directed bench for fsub_issue with a behavioural 3-cycle fsub model and a
// scoreboard queue of expected {y, tag} results.
module tb_fsub_issue;

  localparam int LAT   = 3;
  localparam int DEPTH = 8;
  localparam int TAGW  = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            in_valid, in_ready, in_op, out_valid, out_ready, busy;
  logic [31:0]     in_x1, in_x2, fs_x1, fs_x2, fs_y, out_y;
  logic [TAGW-1:0] in_tag, out_tag;

  int errors  = 0;
  int checks  = 0;
  int pop_cnt = 0;
  logic [32+TAGW-1:0] sb [$];

  always #5 clk = ~clk;

  fsub_issue #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .fs_x1(fs_x1), .fs_x2(fs_x2), .fs_y(fs_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag), .busy(busy)
  );

  // single <-> double conversion for normal numbers (truncating, flush-to-zero)
  function automatic real to_real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0)       d = {f[31], 63'd0};
    else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'd0};
    else                        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] to_single(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e <= 896)  return {d[63], 31'd0};
    if (e >= 1151) return {d[63], 8'hFF, 23'd0};
    return {d[63], 8'(e - 896), d[51:29]};
  endfunction

  function automatic logic [31:0] rand_float();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
  endfunction

  // fsub model: operands registered at edge e produce fs_y sampled at edge e+LAT
  logic [31:0] m1 = '0, m2 = '0;
  always @(posedge clk) begin
    m1 <= to_single(to_real(fs_x1) - to_real(fs_x2));
    m2 <= m1;
  end
  assign fs_y = m2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshakes are sampled mid-cycle; they take effect at the next rising edge.
  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_result", {out_y, out_tag}, '0);
        end else begin
          $display("pop  y=%08h tag=%0d", out_y, out_tag);
          chk("result", {out_y, out_tag}, sb[0]);
          void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        logic [31:0] ey;
        ey = (in_op == 1'b1) ? to_single(to_real(in_x1) + to_real(in_x2))
                             : to_single(to_real(in_x1) - to_real(in_x2));
        $display("push x1=%08h x2=%08h op=%0d tag=%0d", in_x1, in_x2, in_op, in_tag);
        sb.push_back({ey, in_tag});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic op, input logic [31:0] x1, input logic [31:0] x2,
                       input logic [TAGW-1:0] tag);
    in_valid = 1'b1; in_op = op; in_x1 = x1; in_x2 = x2; in_tag = tag;
  endtask

  initial begin
    int acc, base, n;
    rstn = 1'b0; in_valid = 1'b0; in_op = 1'b0; in_x1 = '0; in_x2 = '0;
    in_tag = '0; out_ready = 1'b0;
    repeat (2) step();
    chk("rst_fs_x1", fs_x1, 0);
    chk("rst_fs_x2", fs_x2, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    rstn = 1'b1;
    step();
    chk("idle_in_ready", in_ready, 1);

    // single subtract: latency and sign untouched
    drive(1'b0, 32'h3F800000, 32'h3F000000, 4'd5);
    step();
    in_valid = 1'b0;
    chk("sub_fs_x1", fs_x1, 32'h3F800000);
    chk("sub_fs_x2", fs_x2, 32'h3F000000);
    step(); chk("sub_lat_e1", out_valid, 0);
    step(); chk("sub_lat_e2", out_valid, 0);
    step(); chk("sub_lat_e3", out_valid, 1);
    chk("sub_out_y", out_y, 32'h3F000000);
    chk("sub_out_tag", out_tag, 5);
    out_ready = 1'b1;
    step();
    chk("sub_drained", out_valid, 0);
    chk("sub_busy", busy, 0);

    // add via sign flip
    out_ready = 1'b0;
    drive(1'b1, 32'h3F800000, 32'h3F800000, 4'd2);
    step();
    in_valid = 1'b0;
    chk("add_fs_x2", fs_x2, 32'hBF800000);
    repeat (3) step();
    chk("add_out_valid", out_valid, 1);
    chk("add_out_y", out_y, 32'h40000000);
    chk("add_out_tag", out_tag, 2);
    out_ready = 1'b1;
    step();

    // backpressure: only DEPTH accepts while the consumer stalls
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'($urandom_range(0, 1)), rand_float(), rand_float(), TAGW'(acc));
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    repeat (LAT) step();
    chk("bp_accepts", acc, DEPTH);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_busy", busy, 1);
    base = pop_cnt;
    out_ready = 1'b1;
    n = 0;
    while (pop_cnt - base < DEPTH && n < 30) begin step(); n++; end
    chk("bp_pops", pop_cnt - base, DEPTH);
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_empty_after", out_valid, 0);

    // full throughput, 20 back-to-back ops
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom_range(0, 1)), rand_float(), rand_float(), TAGW'(i));
      chk($sformatf("tp_in_ready_%0d", i), in_ready, 1);
      step();
      if (i >= LAT) chk($sformatf("tp_out_valid_%0d", i), out_valid, 1);
    end
    in_valid = 1'b0;
    for (int i = 20; i < 20 + LAT; i++) begin
      step();
      chk($sformatf("tp_out_valid_%0d", i), out_valid, 1);
    end
    step();
    chk("tp_drained", out_valid, 0);

    // push and pop together at count = DEPTH-1, across pointer wrap
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive(1'($urandom_range(0, 1)), rand_float(), rand_float(), TAGW'(i + 8));
      step();
    end
    in_valid = 1'b0;
    repeat (LAT) step();
    chk("pp_in_ready_7", in_ready, 1);
    drive(1'b0, rand_float(), rand_float(), 4'd15);
    step();
    in_valid = 1'b0;
    chk("pp_in_ready_full_credit", in_ready, 0);
    step(); step();
    base = pop_cnt;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pp_one_pop", pop_cnt - base, 1);
    chk("pp_out_valid", out_valid, 1);
    chk("pp_in_ready_count7", in_ready, 1);
    out_ready = 1'b1;
    n = 0;
    while (pop_cnt - base < DEPTH && n < 30) begin step(); n++; end
    chk("pp_total_pops", pop_cnt - base, DEPTH);
    chk("pp_empty", out_valid, 0);

    // reset with ops in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, rand_float(), rand_float(), TAGW'(i));
      step();
    end
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mr_in_ready", in_ready, 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    step();
    rstn = 1'b1;
    base = pop_cnt;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("mr_no_stale_%0d", i), out_valid, 0);
    end
    chk("mr_busy_after", busy, 0);
    drive(1'b1, 32'h3F800000, 32'h3F000000, 4'd9);
    step();
    in_valid = 1'b0;
    repeat (10) step();
    chk("mr_one_result", pop_cnt - base, 1);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
